data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Data memory stage directly downstream of the ALU.
- The ALU result drives `address`; the register file's second read operand drives `write_data`.
- Reads are combinational, so a single-cycle datapath completes a load in one cycle. Writes commit on the clock edge.
- A reset-triggered init state machine clears every word before the memory accepts accesses.

Parameters:
- ADDR_WIDTH, 8, word-address bits; depth = 2^ADDR_WIDTH 32-bit words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  32  byte address (ALU result).
- write_data  input  32  store data; the low bits are used for byte/half stores.
- mem_read  input  1  load request.
- mem_write  input  1  store request.
- size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- sign_ext  input  1  1 = sign-extend byte/half loads, 0 = zero-extend.
- read_data  output  32  load result.
- misaligned  output  1  access-fault flag for the current request.
- busy  output  1  high while reset is asserted or init is in progress.

Behaviour:
- Storage and addressing:
  - Storage is 2^ADDR_WIDTH x 32.
  - Word index = address[ADDR_WIDTH+1:2]. Address bits above that are ignored, so addresses alias/wrap modulo 4*2^ADDR_WIDTH.
  - Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by address[1:0].
- Init state machine, states INIT and READY:
  - Reset high at a posedge: state <= INIT, clear pointer <= 0. Reset has priority over everything.
  - INIT, reset low: mem[ptr] <= 0 and ptr <= ptr+1 each edge. The edge that clears index 2^ADDR_WIDTH-1 moves state to READY.
  - Init therefore takes exactly 2^ADDR_WIDTH cycles after reset deasserts (256 at default).
  - Reset asserted mid-INIT restarts the sweep at 0.
  - READY is left only by reset.
- busy:
  - busy = reset OR (state == INIT).
  - While busy: stores are ignored, read_data = 0, misaligned = 0.
- Output values after the reset edge: busy = 1, read_data = 0, misaligned = 0.
- misaligned (combinational):
  - Asserted only when (mem_read OR mem_write) and not busy, and one of:
    - size = 01 with address[0] = 1;
    - size = 10 with address[1:0] != 0;
    - size = 11, any address.
  - Otherwise 0.
- Loads (combinational, zero latency):
  - Condition: mem_read = 1, not busy, not misaligned. Otherwise read_data = 0.
  - byte: lane address[1:0], extended to 32 bits per sign_ext.
  - half: bits [31:16] if address[1] = 1, else [15:0], extended per sign_ext.
  - word: full word; sign_ext ignored.
- Stores:
  - Commit at the posedge when mem_write = 1, not busy, not misaligned, reset = 0.
  - Byte: lane address[1:0] <= write_data[7:0].
  - Half: the addressed 16-bit half <= write_data[15:0].
  - Word: whole word <= write_data.
  - Unaddressed lanes keep their value.
  - A misaligned or busy store leaves memory unchanged.
- mem_read and mem_write both high:
  - The store commits at the edge.
  - read_data reflects pre-edge contents (read-before-write), then updates combinationally after the edge.
- No internal state other than memory contents, state, and ptr.

Test Plan:
- Reset pulse, then count busy cycles.
  - busy is high for exactly 256 cycles after reset release, then low.
  - lw 0x40 -> 0x00000000.
- Word store and mixed loads: sw 0xDEADBEEF @0x10, then:
  - lw 0x10 -> 0xDEADBEEF
  - lb 0x11 (sign_ext = 1) -> 0xFFFFFFBE
  - lbu 0x11 -> 0x000000BE
  - lh 0x12 (sign_ext = 1) -> 0xFFFFDEAD
  - lhu 0x10 -> 0x0000BEEF
- Partial stores over that word:
  - sb write_data = 0x12345655 @0x13 -> lw 0x10 = 0x55ADBEEF.
  - Then sh write_data = 0x0000CAFE @0x10 -> lw 0x10 = 0x55ADCAFE.
- Misalignment:
  - sw @0x12 -> misaligned = 1 and memory unchanged (lw 0x10 unchanged).
  - lh @0x11 -> misaligned = 1, read_data = 0.
  - size = 11 @0x10 -> misaligned = 1.
- Wrap and simultaneous access:
  - sw 0x12345678 @0x400 -> lw 0x0 = 0x12345678.
  - mem_read + mem_write of 0xAAAAAAAA @0x0 in the same cycle -> read_data = 0x12345678 before the edge, 0xAAAAAAAA after.
- Reset mid-init and while READY:
  - Reset reasserted at init cycle 100 -> busy stays high for a further 256 cycles after release.
  - sw attempted while busy -> ignored; lw afterwards -> 0.
  - Reset while READY -> all previously written words read 0 after init.

Source files
------------

// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressable data memory with combinational loads and a reset-driven clear sweep
// Reads are zero-latency; stores and the clear sweep share one byte-masked write port.
module data_memory #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] read_data,
    output logic        misaligned,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [ADDR_WIDTH-1:0]   w_next_ptr;
    logic [31:0]             r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   w_index;
    logic [31:0]             w_word;
    logic                    w_access;
    logic                    w_store_ok;
    logic                    w_load_ok;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_waddr;
    logic [31:0]             w_wdata;
    logic [3:0]              w_wmask;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_load;
    logic                    w_unused_addr;

    // High address bits alias onto the same words.
    assign w_index       = address[ADDR_WIDTH+1:2];
    assign w_unused_addr = ^address[31:ADDR_WIDTH+2];
    assign w_word        = r_mem[w_index];

    assign busy     = reset | (r_state == INIT);
    assign w_access = (mem_read | mem_write) & ~busy;

    always_comb begin
        misaligned = 1'b0;
        if (w_access) begin
            case (size)
                2'b01:   misaligned = address[0];
                2'b10:   misaligned = (address[1:0] != 2'b00);
                2'b11:   misaligned = 1'b1;
                default: misaligned = 1'b0;
            endcase
        end
    end

    assign w_store_ok = mem_write & ~busy & ~misaligned;
    assign w_load_ok  = mem_read & ~busy & ~misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        if (r_state == INIT) begin
            w_next_ptr = r_ptr + 1'b1;
            if (r_ptr == {ADDR_WIDTH{1'b1}})
                w_next_state = READY;
        end
    end

    // Single write port: the clear sweep owns it during INIT, stores otherwise.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_index;
        w_wdata = write_data;
        w_wmask = 4'b0000;
        if (!reset) begin
            if (r_state == INIT) begin
                w_we    = 1'b1;
                w_waddr = r_ptr;
                w_wdata = 32'h0;
                w_wmask = 4'b1111;
            end else if (w_store_ok) begin
                w_we = 1'b1;
                case (size)
                    2'b00: begin
                        w_wdata = {4{write_data[7:0]}};
                        w_wmask = 4'b0001 << address[1:0];
                    end
                    2'b01: begin
                        w_wdata = {2{write_data[15:0]}};
                        w_wmask = address[1] ? 4'b1100 : 4'b0011;
                    end
                    default: begin
                        w_wdata = write_data;
                        w_wmask = 4'b1111;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wmask[k])
                    r_mem[w_waddr][8*k +: 8] <= w_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        case (address[1:0])
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = address[1] ? w_word[31:16] : w_word[15:0];
    end

    always_comb begin
        case (size)
            2'b00:   w_load = sign_ext ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            2'b01:   w_load = sign_ext ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            2'b10:   w_load = w_word;
            default: w_load = 32'h0;
        endcase
    end

    assign read_data = w_load_ok ? w_load : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed self-checking bench for data_memory
// Inputs change 1ns after each rising edge; outputs are sampled there as well.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] read_data;
    logic        misaligned;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    data_memory #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .size       (size),
        .sign_ext   (sign_ext),
        .read_data  (read_data),
        .misaligned (misaligned),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] sz, input logic sx);
        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        write_data = data;
        size       = sz;
        sign_ext   = sx;
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
        drive(1'b0, 1'b1, addr, data, sz, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    endtask

    task automatic test_reset();
        int cnt;
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b1 || read_data !== 32'h0 || misaligned !== 1'b0) begin
            $display("FAIL reset_outputs busy=%b rd=%h mis=%b required busy=1 rd=0 mis=0",
                     busy, read_data, misaligned);
            tests_failed++;
        end
        reset = 1'b0;
        #1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            tick();
            cnt++;
            if (cnt == 10) begin
                tests_run++;
                if (read_data !== 32'h0) begin
                    $display("FAIL init_read_zero rd=%h required 00000000", read_data);
                    tests_failed++;
                end
            end
        end
        tests_run++;
        if (cnt != 256) begin
            $display("FAIL init_busy_cycles got %0d required 256", cnt);
            tests_failed++;
        end
        drive(1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0);
        tests_run++;
        if (read_data !== 32'h0) begin
            $display("FAIL lw_0x40_after_init rd=%h required 00000000", read_data);
            tests_failed++;
        end
    endtask

    task automatic test_word_and_loads();
        logic [31:0] addrs [5];
        logic [1:0]  szs   [5];
        logic        sxs   [5];
        logic [31:0] exps  [5];
        addrs = '{32'h10, 32'h11, 32'h11, 32'h12, 32'h10};
        szs   = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
        sxs   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exps  = '{32'hDEADBEEF, 32'hFFFFFFBE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000BEEF};
        store(32'h10, 32'hDEADBEEF, 2'b10);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, addrs[i], 32'h0, szs[i], sxs[i]);
            tests_run++;
            if (read_data !== exps[i] || misaligned !== 1'b0) begin
                $display("FAIL load_%0d rd=%h mis=%b required rd=%h mis=0",
                         i, read_data, misaligned, exps[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_partial_stores();
        store(32'h13, 32'h12345655, 2'b00);
        drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        tests_run++;
        if (read_data !== 32'h55ADBEEF) begin
            $display("FAIL sb_0x13 rd=%h required 55ADBEEF", read_data);
            tests_failed++;
        end
        store(32'h10, 32'h0000CAFE, 2'b01);
        drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        tests_run++;
        if (read_data !== 32'h55ADCAFE) begin
            $display("FAIL sh_0x10 rd=%h required 55ADCAFE", read_data);
            tests_failed++;
        end
    endtask

    task automatic test_misaligned();
        drive(1'b0, 1'b1, 32'h12, 32'h99999999, 2'b10, 1'b0);
        tests_run++;
        if (misaligned !== 1'b1) begin
            $display("FAIL sw_0x12_flag mis=%b required 1", misaligned);
            tests_failed++;
        end
        tick();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        tests_run++;
        if (read_data !== 32'h55ADCAFE) begin
            $display("FAIL sw_0x12_no_write rd=%h required 55ADCAFE", read_data);
            tests_failed++;
        end
        drive(1'b1, 1'b0, 32'h11, 32'h0, 2'b01, 1'b1);
        tests_run++;
        if (misaligned !== 1'b1 || read_data !== 32'h0) begin
            $display("FAIL lh_0x11 mis=%b rd=%h required mis=1 rd=00000000", misaligned, read_data);
            tests_failed++;
        end
        drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0);
        tests_run++;
        if (misaligned !== 1'b1 || read_data !== 32'h0) begin
            $display("FAIL size11 mis=%b rd=%h required mis=1 rd=00000000", misaligned, read_data);
            tests_failed++;
        end
        drive(1'b0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0);
        tests_run++;
        if (misaligned !== 1'b0) begin
            $display("FAIL idle_no_flag mis=%b required 0", misaligned);
            tests_failed++;
        end
    endtask

    task automatic test_wrap();
        store(32'h400, 32'h12345678, 2'b10);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        tests_run++;
        if (read_data !== 32'h12345678) begin
            $display("FAIL wrap_0x400 rd=%h required 12345678", read_data);
            tests_failed++;
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 32'h0, 32'hAAAAAAAA, 2'b10, 1'b0);
        tests_run++;
        if (read_data !== 32'h12345678) begin
            $display("FAIL rw_pre_edge rd=%h required 12345678", read_data);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (read_data !== 32'hAAAAAAAA) begin
            $display("FAIL rw_post_edge rd=%h required AAAAAAAA", read_data);
            tests_failed++;
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    endtask

    task automatic test_reset_mid_init();
        int cnt;
        store(32'h20, 32'hCAFEF00D, 2'b10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        tests_run++;
        if (busy !== 1'b1) begin
            $display("FAIL busy_at_cycle_100 busy=%b required 1", busy);
            tests_failed++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b1, 32'h44, 32'h11111111, 2'b10, 1'b0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            tick();
            cnt++;
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        tests_run++;
        if (cnt != 256) begin
            $display("FAIL restart_busy_cycles got %0d required 256", cnt);
            tests_failed++;
        end
        drive(1'b1, 1'b0, 32'h44, 32'h0, 2'b10, 1'b0);
        tests_run++;
        if (read_data !== 32'h0) begin
            $display("FAIL busy_store_ignored rd=%h required 00000000", read_data);
            tests_failed++;
        end
        drive(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
        tests_run++;
        if (read_data !== 32'h0) begin
            $display("FAIL cleared_0x20 rd=%h required 00000000", read_data);
            tests_failed++;
        end
        drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        tests_run++;
        if (read_data !== 32'h0) begin
            $display("FAIL cleared_0x10 rd=%h required 00000000", read_data);
            tests_failed++;
        end
        drive(1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        tests_run++;
        if (read_data !== 32'h0) begin
            $display("FAIL cleared_0x0 rd=%h required 00000000", read_data);
            tests_failed++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        address    = 32'h0;
        write_data = 32'h0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        size       = 2'b10;
        sign_ext   = 1'b0;
        test_reset();
        test_word_and_loads();
        test_partial_stores();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        test_reset_mid_init();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
